// File: rtl/qpsk_hls_top_mul_pkg.sv
// rtl/qpsk_hls_top_mul_pkg.sv - shared bounds and width/rounding helpers for the multiply-accumulate pipe
package qpsk_hls_top_mul_pkg;

  localparam int NUM_STAGE_MIN = 2;
  localparam int NUM_STAGE_MAX = 8;

  // Both operands are extended to this width so one signed multiply covers every signedness mix.
  function automatic int prod_width(input int a_w, input int b_w);
    return a_w + b_w + 1;
  endfunction

  function automatic logic [63:0] round_const(input int shift);
    if (shift > 0) return 64'd1 << (shift - 1);
    return 64'd0;
  endfunction

endpackage

// File: rtl/qpsk_hls_top_mul_round_sat.sv
// rtl/qpsk_hls_top_mul_round_sat.sv - round-half-up, arithmetic right shift and saturation to the output width
module qpsk_hls_top_mul_round_sat
  import qpsk_hls_top_mul_pkg::*;
#(
  parameter int ACC_WIDTH = 48,
  parameter int OUT_SHIFT = 0,
  parameter int OUT_WIDTH = 39,
  parameter bit IS_SIGNED = 1'b0
) (
  input  logic [ACC_WIDTH-1:0] value,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 sat
);

  // Two guard bits: one keeps unsigned values positive, one absorbs the rounding carry.
  localparam int EXT = ACC_WIDTH + 2;
  localparam int MAG = IS_SIGNED ? OUT_WIDTH - 1 : OUT_WIDTH;
  localparam logic signed [EXT-1:0] SAT_MAX = (EXT'(1) <<< MAG) - EXT'(1);
  localparam logic signed [EXT-1:0] SAT_MIN = IS_SIGNED ? -(EXT'(1) <<< MAG) : EXT'(0);
  localparam logic signed [EXT-1:0] RND     = EXT'(round_const(OUT_SHIFT));

  logic signed [EXT-1:0] v_ext;
  logic signed [EXT-1:0] rounded;
  logic signed [EXT-1:0] shifted;

  always_comb begin
    v_ext   = {{2{IS_SIGNED & value[ACC_WIDTH-1]}}, value};
    rounded = v_ext + RND;
    shifted = rounded >>> OUT_SHIFT;
    dout    = shifted[OUT_WIDTH-1:0];
    sat     = 1'b0;
    if (shifted > SAT_MAX) begin
      dout = SAT_MAX[OUT_WIDTH-1:0];
      sat  = 1'b1;
    end else if (shifted < SAT_MIN) begin
      dout = SAT_MIN[OUT_WIDTH-1:0];
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/qpsk_hls_top_mul_pipe_acc.sv
// rtl/qpsk_hls_top_mul_pipe_acc.sv - pipelined multiplier with optional accumulate, rounding and saturation
module qpsk_hls_top_mul_pipe_acc
  import qpsk_hls_top_mul_pkg::*;
#(
  parameter int A_WIDTH   = 18,
  parameter int B_WIDTH   = 21,
  parameter int A_SIGNED  = 0,
  parameter int B_SIGNED  = 0,
  parameter int NUM_STAGE = 4,
  parameter int ACC_WIDTH = 48,
  parameter int OUT_SHIFT = 0,
  parameter int OUT_WIDTH = 39
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  input  logic                 acc_en,
  input  logic                 acc_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 dout_sat
);

  // Out-of-range depths are clamped to the nearest legal pipeline depth.
  localparam int STAGES = (NUM_STAGE < NUM_STAGE_MIN) ? NUM_STAGE_MIN :
                          (NUM_STAGE > NUM_STAGE_MAX) ? NUM_STAGE_MAX : NUM_STAGE;
  localparam int MID = STAGES - 1;
  localparam int EW  = prod_width(A_WIDTH, B_WIDTH);
  localparam bit A_SX = (A_SIGNED != 0);
  localparam bit B_SX = (B_SIGNED != 0);
  localparam bit IS_SIGNED = A_SX || B_SX;

  logic                  adv;
  logic [MID-1:0]        v_pipe;
  logic [MID-1:0]        en_pipe;
  logic [MID-1:0]        clr_pipe;
  logic [A_WIDTH-1:0]    a_r;
  logic [B_WIDTH-1:0]    b_r;
  logic signed [EW-1:0]  a_x;
  logic signed [EW-1:0]  b_x;
  logic signed [EW-1:0]  prod_comb;
  logic signed [EW-1:0]  prod_fin;
  logic                  fin_v;
  logic                  fin_en;
  logic                  fin_clr;
  logic [ACC_WIDTH-1:0]  acc;
  logic [ACC_WIDTH-1:0]  acc_next;
  logic [ACC_WIDTH-1:0]  prod_acc;
  logic [ACC_WIDTH-1:0]  value;
  logic [OUT_WIDTH-1:0]  rs_dout;
  logic                  rs_sat;

  assign adv      = ce && (!out_valid || out_ready);
  assign in_ready = adv;

  always_ff @(posedge clk) begin
    if (!reset) begin
      v_pipe <= '0;
    end else if (adv) begin
      v_pipe[0] <= in_valid;
      for (int i = 1; i < MID; i++) v_pipe[i] <= v_pipe[i-1];
    end
  end

  // Operand and tag registers carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (adv) begin
      a_r         <= a;
      b_r         <= b;
      en_pipe[0]  <= acc_en;
      clr_pipe[0] <= acc_clr;
      for (int i = 1; i < MID; i++) begin
        en_pipe[i]  <= en_pipe[i-1];
        clr_pipe[i] <= clr_pipe[i-1];
      end
    end
  end

  always_comb begin
    a_x       = {{(EW-A_WIDTH){A_SX & a_r[A_WIDTH-1]}}, a_r};
    b_x       = {{(EW-B_WIDTH){B_SX & b_r[B_WIDTH-1]}}, b_r};
    prod_comb = a_x * b_x;
  end

  // The first product register maps to the DSP M register; deeper pipes just delay it.
  generate
    if (MID == 1) begin : g_comb_prod
      assign prod_fin = prod_comb;
    end else begin : g_reg_prod
      logic signed [EW-1:0] prod_pipe [MID-1];
      always_ff @(posedge clk) begin
        if (adv) begin
          prod_pipe[0] <= prod_comb;
          for (int i = 1; i < MID - 1; i++) prod_pipe[i] <= prod_pipe[i-1];
        end
      end
      assign prod_fin = prod_pipe[MID-2];
    end
  endgenerate

  always_comb begin
    fin_v    = v_pipe[MID-1];
    fin_en   = en_pipe[MID-1];
    fin_clr  = clr_pipe[MID-1];
    prod_acc = ACC_WIDTH'(prod_fin);
    acc_next = (fin_clr ? '0 : acc) + prod_acc;
    value    = fin_en ? acc_next : prod_acc;
  end

  qpsk_hls_top_mul_round_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_SHIFT (OUT_SHIFT),
    .OUT_WIDTH (OUT_WIDTH),
    .IS_SIGNED (IS_SIGNED)
  ) u_round_sat (
    .value (value),
    .dout  (rs_dout),
    .sat   (rs_sat)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      acc       <= '0;
      dout      <= '0;
      dout_sat  <= 1'b0;
    end else if (adv) begin
      out_valid <= fin_v;
      if (fin_v) begin
        dout     <= rs_dout;
        dout_sat <= rs_sat;
        if (fin_en) acc <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_qpsk_hls_top_mul_pipe_acc.sv
// tb/tb_qpsk_hls_top_mul_pipe_acc.sv - bench for three configurations of the multiply-accumulate pipe
module tb_qpsk_hls_top_mul_pipe_acc;

  localparam int NS = 4;
  localparam int M_SGN [3] = '{0, 1, 0};
  localparam int M_SH  [3] = '{0, 0, 4};
  localparam int M_OW  [3] = '{39, 39, 8};

  logic clk = 1'b0;
  logic reset = 1'b0, ce = 1'b0, in_valid = 1'b0, acc_en = 1'b0, acc_clr = 1'b0, out_ready = 1'b1;
  logic [17:0] a = '0;
  logic [20:0] b = '0;
  logic ir_d, ov_d, sat_d, ir_s, ov_s, sat_s, ir_h, ov_h, sat_h;
  logic [38:0] dout_d, dout_s;
  logic [7:0]  dout_h;

  always #5 clk = ~clk;

  qpsk_hls_top_mul_pipe_acc u_def (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(ir_d), .a(a), .b(b),
    .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov_d), .out_ready(out_ready),
    .dout(dout_d), .dout_sat(sat_d));

  qpsk_hls_top_mul_pipe_acc #(.A_SIGNED(1), .B_SIGNED(1)) u_sgn (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(ir_s), .a(a), .b(b),
    .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov_s), .out_ready(out_ready),
    .dout(dout_s), .dout_sat(sat_s));

  qpsk_hls_top_mul_pipe_acc #(.OUT_SHIFT(4), .OUT_WIDTH(8)) u_shf (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(ir_h), .a(a), .b(b),
    .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov_h), .out_ready(out_ready),
    .dout(dout_h), .dout_sat(sat_h));

  int n_checks = 0;
  int n_pass = 0;
  int pops = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, 64'(act), 64'(exp));
  endtask

  typedef struct {
    int              age;
    logic [2:0][63:0] d;
    logic [2:0]       s;
  } beat_t;

  beat_t       q[$];
  logic [47:0] m_acc [3];

  function automatic void model_beat(input int m, input logic [17:0] av, input logic [20:0] bv,
                                     input logic en, input logic clr,
                                     output logic [63:0] d, output logic s);
    longint p, v, r, hi, lo;
    logic [47:0] nacc;
    if (M_SGN[m] != 0) p = longint'($signed(av)) * longint'($signed(bv));
    else p = longint'({46'd0, av}) * longint'({43'd0, bv});
    if (en) begin
      nacc = (clr ? 48'd0 : m_acc[m]) + p[47:0];
      m_acc[m] = nacc;
      if (M_SGN[m] != 0) v = longint'($signed(nacc));
      else v = longint'({16'd0, nacc});
    end else begin
      v = p;
    end
    r = (v + ((M_SH[m] > 0) ? (64'sd1 <<< (M_SH[m] - 1)) : 64'sd0)) >>> M_SH[m];
    if (M_SGN[m] != 0) begin
      hi = (64'sd1 <<< (M_OW[m] - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
    end else begin
      hi = (64'sd1 <<< M_OW[m]) - 64'sd1;
      lo = 64'sd0;
    end
    d = r;
    s = 1'b0;
    if (r > hi) begin d = hi; s = 1'b1; end
    else if (r < lo) begin d = lo; s = 1'b1; end
  endfunction

  always @(posedge clk) begin : model_p
    beat_t nb;
    bit head;
    logic [63:0] dt;
    logic st;
    if (!reset) begin
      q.delete();
      for (int m = 0; m < 3; m++) m_acc[m] = '0;
    end else begin
      head = (q.size() > 0) && (q[0].age == NS);
      if (ce && (!head || out_ready)) begin
        if (head) nb = q.pop_front();
        foreach (q[i]) q[i].age = q[i].age + 1;
        if (in_valid) begin
          nb.age = 1;
          for (int m = 0; m < 3; m++) begin
            model_beat(m, a, b, acc_en, acc_clr, dt, st);
            nb.d[m] = dt;
            nb.s[m] = st;
          end
          q.push_back(nb);
        end
      end
    end
  end

  always begin : cmp_p
    bit eov;
    @(negedge clk);
    #3;
    if (chk_en) begin
      eov = (q.size() > 0) && (q[0].age == NS);
      check_bit("in_ready_def", ir_d, ce && (!eov || out_ready));
      check_bit("in_ready_sgn", ir_s, ce && (!eov || out_ready));
      check_bit("in_ready_shf", ir_h, ce && (!eov || out_ready));
      check_bit("out_valid_def", ov_d, eov);
      check_bit("out_valid_sgn", ov_s, eov);
      check_bit("out_valid_shf", ov_h, eov);
      if (eov) begin
        check("dout_def", 64'(dout_d), 64'(q[0].d[0][38:0]));
        check("dout_sgn", 64'(dout_s), 64'(q[0].d[1][38:0]));
        check("dout_shf", 64'(dout_h), 64'(q[0].d[2][7:0]));
        check_bit("sat_def", sat_d, q[0].s[0]);
        check_bit("sat_sgn", sat_s, q[0].s[1]);
        check_bit("sat_shf", sat_h, q[0].s[2]);
      end
      if (ov_d && out_ready && ce && reset) pops++;
    end
  end

  task automatic wait_out(output int lat);
    lat = 0;
    while (!ov_d && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_bit("wait_out_valid", ov_d, 1'b1);
  endtask

  task automatic beat_wait(input logic [17:0] av, input logic [20:0] bv, input logic en,
                           input logic clr, output int lat);
    a = av; b = bv; acc_en = en; acc_clr = clr; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
    wait_out(lat);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin : stim
    int lat, pops0, k;
    logic [38:0] stall_dout;
    bit acc_ok;
    ce = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    chk_en = 1'b1;
    #1;
    check_bit("reset_out_valid", ov_d, 1'b0);
    check("reset_dout", 64'(dout_d), 64'd0);

    beat_wait(18'h3FFFF, 21'h1FFFFF, 1'b0, 1'b0, lat);
    check("dflt_latency", 64'(lat), 64'd3);
    check("dflt_dout", 64'(dout_d), 64'h7F_FFDC_0001);
    check_bit("dflt_sat", sat_d, 1'b0);

    beat_wait(18'h3FFFD, 21'd5, 1'b0, 1'b0, lat);
    check("sgn_neg15", 64'(dout_s), 64'h7F_FFFF_FFF1);
    beat_wait(18'h20000, 21'h100000, 1'b0, 1'b0, lat);
    check("sgn_2p37", 64'(dout_s), 64'h20_0000_0000);

    beat_wait(18'd2, 21'd3, 1'b1, 1'b1, lat);
    check("acc_6", 64'(dout_d), 64'd6);
    beat_wait(18'd4, 21'd5, 1'b1, 1'b0, lat);
    check("acc_26", 64'(dout_d), 64'd26);
    beat_wait(18'd1, 21'd1, 1'b1, 1'b0, lat);
    check("acc_27", 64'(dout_d), 64'd27);
    beat_wait(18'd7, 21'd7, 1'b1, 1'b1, lat);
    check("acc_clr_49", 64'(dout_d), 64'd49);

    beat_wait(18'h18, 21'd1, 1'b0, 1'b0, lat);
    check("shf_0x18", 64'(dout_h), 64'd2);
    beat_wait(18'h17, 21'd1, 1'b0, 1'b0, lat);
    check("shf_0x17", 64'(dout_h), 64'd1);
    beat_wait(18'hFFFF, 21'd1, 1'b0, 1'b0, lat);
    check("shf_sat_val", 64'(dout_h), 64'd255);
    check_bit("shf_sat_flag", sat_h, 1'b1);

    a = 18'd9; b = 21'd9; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; ce = 1'b0;
    repeat (3) begin
      #1;
      check_bit("ce_in_ready_low", ir_d, 1'b0);
      @(negedge clk);
    end
    ce = 1'b1;
    wait_out(lat);
    check("ce_dout", 64'(dout_d), 64'd81);

    repeat (2) @(negedge clk);
    pops0 = pops;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      out_ready = !(c >= 5 && c <= 7);
      if (k < 6) begin
        a = 18'(10 + k); b = 21'(k + 1); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c == 5) stall_dout = dout_d;
      if (c >= 5 && c <= 7) check_bit("bp_in_ready_low", ir_d, 1'b0);
      if (c == 6 || c == 7) check("bp_dout_hold", 64'(dout_d), 64'(stall_dout));
      acc_ok = in_valid && ir_d;
      @(negedge clk);
      if (acc_ok) k++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp_beats_in", 64'(k), 64'd6);
    check("bp_results_out", 64'(pops - pops0), 64'd6);

    for (int i = 0; i < 3; i++) begin
      a = 18'(i + 1); b = 21'(i + 1); acc_en = 1'b1; acc_clr = (i == 0); in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0; acc_en = 1'b0; acc_clr = 1'b0; reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_bit("rst_out_valid", ov_d, 1'b0);
    repeat (6) begin
      @(negedge clk);
      check_bit("rst_no_stale", ov_d, 1'b0);
    end
    beat_wait(18'd5, 21'd5, 1'b1, 1'b0, lat);
    check("rst_acc_from_0", 64'(dout_d), 64'd25);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
